jesd_tx_link: RTL and testbench

Two-lane JESD204B transmit link layer. It drives code-group synchronisation (/K/), the initial lane alignment sequence (ILAS), and then user data onto a 32-bit, 2-octet-per-lane-per-clock bus toward the serializer. It reacts to the receiver's SYNC~ request, including mid-link resynchronisation, and aligns every phase change to the local multiframe clock (`lmfc_edge`).

---
 rtl/jesd_tx_link_if.sv | 22 ++
 rtl/jesd_tx_link.sv | 170 +++++++++++++++++
 tb/tb_jesd_tx_link.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jesd_tx_link_if.sv
// Signal bundle between the JESD204B transmit link layer and its user/serializer side.
interface jesd_tx_link_if;
  logic         lmfc_edge;
  logic         sync_n;
  logic [31:0]  data_i;
  logic [111:0] cfg_i;
  logic [31:0]  data_o;
  logic [3:0]   datak_o;
  logic         tx_ready_o;
  logic [1:0]   state_o;
  logic [7:0]   resync_cnt_o;

  modport master (
    output lmfc_edge, sync_n, data_i, cfg_i,
    input  data_o, datak_o, tx_ready_o, state_o, resync_cnt_o
  );

  modport slave (
    input  lmfc_edge, sync_n, data_i, cfg_i,
    output data_o, datak_o, tx_ready_o, state_o, resync_cnt_o
  );
endinterface

// File: rtl/jesd_tx_link.sv
// Two-lane JESD204B transmit link layer: CGS, ILAS and user data framing, with every
// phase change aligned to the local multiframe clock and SYNC~-driven resynchronisation.
module jesd_tx_link #(
  parameter int unsigned MF_BEATS  = 8,
  parameter int unsigned ILAS_MF   = 4,
  parameter int unsigned SYNC_FILT = 4
) (
  input logic           clk,
  input logic           rst,
  jesd_tx_link_if.slave bus
);
  localparam int unsigned BW = $clog2(MF_BEATS);
  localparam int unsigned JW = BW + 1;
  localparam int unsigned MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int unsigned FW = $clog2(SYNC_FILT + 1);
  localparam logic [BW-1:0] BeatLast = BW'(MF_BEATS - 1);
  localparam logic [MW-1:0] MfLast   = MW'(ILAS_MF - 1);
  localparam logic [FW-1:0] FiltLast = FW'(SYNC_FILT - 1);

  typedef enum logic [1:0] {StCgs = 2'd0, StIlas = 2'd1, StData = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          sync_meta_q, sync_s_q;
  logic [BW-1:0] beat_q, beat_d, cur_beat;
  logic [MW-1:0] mf_q, mf_d;
  logic [FW-1:0] filt_q, filt_d;
  logic          armed_q, armed_d;
  logic [7:0]    resync_cnt_q, resync_cnt_d;
  logic          resync;
  logic [31:0]   data_q, data_d;
  logic [3:0]    datak_q, datak_d;
  logic          tx_ready;
  logic [JW-1:0] j_lo, j_hi;
  logic [8:0]    oct_lo, oct_hi;
  logic [7:0]    cfg_oct [16];

  // Pad the config table to a power of two so the lookup index never runs off the end.
  for (genvar g = 0; g < 16; g++) begin : g_cfg
    if (g < 14) begin : g_oct
      assign cfg_oct[g] = bus.cfg_i[8*g +: 8];
    end else begin : g_pad
      assign cfg_oct[g] = 8'h00;
    end
  end

  // Returns {k, octet} for lane octet j of ILAS multiframe m.
  function automatic logic [8:0] ilas_octet(input logic [MW-1:0] m, input logic [JW-1:0] j,
                                            input logic [7:0] cfg_val);
    int unsigned jn;
    jn = 32'(j);
    if (jn == 0) return {1'b1, 8'h1C};
    if (jn == 2 * MF_BEATS - 1) return {1'b1, 8'h7C};
    if (m == MW'(1) && jn == 1) return {1'b1, 8'h9C};
    if (m == MW'(1) && jn <= 32'd15) return {1'b0, cfg_val};
    return {1'b0, 8'(jn)};
  endfunction

  // An lmfc_edge pins the current beat to 0 even if the counter has drifted.
  always_comb begin
    cur_beat = bus.lmfc_edge ? '0 : beat_q;
    if (bus.lmfc_edge) begin
      beat_d = BW'(1);
    end else if (beat_q == BeatLast) begin
      beat_d = '0;
    end else begin
      beat_d = beat_q + BW'(1);
    end
  end

  assign j_lo   = {cur_beat, 1'b0};
  assign j_hi   = {cur_beat, 1'b1};
  assign oct_lo = ilas_octet(mf_q, j_lo, cfg_oct[4'(j_lo - JW'(2))]);
  assign oct_hi = ilas_octet(mf_q, j_hi, cfg_oct[4'(j_hi - JW'(2))]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCgs;
      sync_meta_q  <= 1'b1;
      sync_s_q     <= 1'b1;
      beat_q       <= '0;
      mf_q         <= '0;
      filt_q       <= '0;
      armed_q      <= 1'b0;
      resync_cnt_q <= '0;
      data_q       <= '0;
      datak_q      <= '0;
    end else begin
      state_q      <= state_d;
      sync_meta_q  <= bus.sync_n;
      sync_s_q     <= sync_meta_q;
      beat_q       <= beat_d;
      mf_q         <= mf_d;
      filt_q       <= filt_d;
      armed_q      <= armed_d;
      resync_cnt_q <= resync_cnt_d;
      data_q       <= data_d;
      datak_q      <= datak_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mf_d         = mf_q;
    filt_d       = '0;
    resync       = 1'b0;
    case (state_q)
      StCgs: begin
        if (cur_beat == BeatLast && armed_q && sync_s_q) begin
          state_d = StIlas;
          mf_d    = '0;
        end
      end
      StIlas, StData: begin
        if (!sync_s_q) filt_d = filt_q + FW'(1);
        // Resync takes priority over the end of ILAS.
        if (!sync_s_q && filt_q == FiltLast) begin
          resync  = 1'b1;
          state_d = StCgs;
          filt_d  = '0;
          mf_d    = '0;
        end else if (state_q == StIlas && cur_beat == BeatLast) begin
          if (mf_q == MfLast) begin
            state_d = StData;
            mf_d    = '0;
          end else begin
            mf_d = mf_q + MW'(1);
          end
        end
      end
      default: state_d = StCgs;
    endcase

    armed_d = armed_q;
    if (resync) begin
      armed_d = 1'b0;
    end else if (!sync_s_q) begin
      armed_d = 1'b1;
    end

    resync_cnt_d = resync_cnt_q;
    if (resync && resync_cnt_q != 8'hFF) resync_cnt_d = resync_cnt_q + 8'd1;
  end

  always_comb begin
    data_d   = '0;
    datak_d  = '0;
    tx_ready = 1'b0;
    case (state_q)
      StCgs: begin
        data_d  = 32'hBCBC_BCBC;
        datak_d = 4'hF;
      end
      StIlas: begin
        data_d  = {oct_hi[7:0], oct_lo[7:0], oct_hi[7:0], oct_lo[7:0]};
        datak_d = {oct_hi[8], oct_lo[8], oct_hi[8], oct_lo[8]};
      end
      StData: begin
        data_d   = bus.data_i;
        tx_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.data_o       = data_q;
  assign bus.datak_o      = datak_q;
  assign bus.tx_ready_o   = tx_ready;
  assign bus.state_o      = state_q;
  assign bus.resync_cnt_o = resync_cnt_q;
endmodule

// File: tb/tb_jesd_tx_link.sv
// Bench for jesd_tx_link: directed vector table for the link bring-up, hand-written corner
// sequences, and a randomized run against a multiframe-arithmetic reference model.
module tb_jesd_tx_link;
  localparam int MF   = 8;
  localparam int NMF  = 4;
  localparam int FILT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jesd_tx_link_if bus ();

  jesd_tx_link #(.MF_BEATS(MF), .ILAS_MF(NMF), .SYNC_FILT(FILT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          off;
    logic [31:0] din;
    logic [31:0] data;
    logic [3:0]  k;
    logic [1:0]  st;
    logic        rdy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] cfg_oct [14];
  int lmfc_cnt = 0;
  bit early = 1'b0;

  // Reference model state
  int cyc = 0;
  int anchor = 0;
  bit sq[$] = '{1'b1, 1'b1};
  int md_mode = 0, md_mf = 0, md_low = 0, md_rcnt = 0;
  bit md_armed = 1'b0;
  logic [31:0] md_data = '0;
  logic [3:0]  md_k = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] ilas_oct(input int m, input int j);
    if (j == 0) return {1'b1, 8'h1C};
    if (j == 2 * MF - 1) return {1'b1, 8'h7C};
    if (m == 1 && j == 1) return {1'b1, 8'h9C};
    if (m == 1 && j <= 15) return {1'b0, cfg_oct[j-2]};
    return {1'b0, 8'(j)};
  endfunction

  task automatic load_cfg();
    logic [111:0] cfgv;
    cfgv = '0;
    for (int n = 13; n >= 0; n--) cfgv = {cfgv[103:0], cfg_oct[n]};
    bus.cfg_i = cfgv;
  endtask

  // Beat is the distance to the most recent multiframe edge (or reset release), mod MF.
  task automatic model_step();
    int beat;
    bit s;
    bit rs;
    logic [8:0] o0, o1;
    if (rst) begin
      md_data = '0; md_k = '0; md_mode = 0; md_armed = 1'b0;
      md_mf = 0; md_low = 0; md_rcnt = 0;
      sq.delete(); sq.push_back(1'b1); sq.push_back(1'b1);
      anchor = cyc + 1;
    end else begin
      if (bus.lmfc_edge) anchor = cyc;
      beat = (cyc - anchor) % MF;
      s = sq.pop_front();
      sq.push_back(bus.sync_n);
      case (md_mode)
        0: begin md_data = 32'hBCBC_BCBC; md_k = 4'hF; end
        1: begin
          o0 = ilas_oct(md_mf, 2 * beat);
          o1 = ilas_oct(md_mf, 2 * beat + 1);
          md_data = {o1[7:0], o0[7:0], o1[7:0], o0[7:0]};
          md_k    = {o1[8], o0[8], o1[8], o0[8]};
        end
        default: begin md_data = bus.data_i; md_k = 4'h0; end
      endcase
      rs = 1'b0;
      if (md_mode == 0) begin
        if (beat == MF - 1 && md_armed && s) begin md_mode = 1; md_mf = 0; end
      end else begin
        md_low = s ? 0 : md_low + 1;
        if (md_low >= FILT) begin
          rs = 1'b1; md_mode = 0; md_low = 0; md_mf = 0;
          if (md_rcnt < 255) md_rcnt++;
        end else if (md_mode == 1 && beat == MF - 1) begin
          if (md_mf == NMF - 1) begin md_mode = 2; md_mf = 0; end
          else md_mf++;
        end
      end
      if (rs) md_armed = 1'b0;
      else if (!s) md_armed = 1'b1;
    end
    cyc++;
  endtask

  task automatic cycle();
    bus.lmfc_edge = early || (lmfc_cnt == 0);
    model_step();
    @(posedge clk);
    #1;
    lmfc_cnt = bus.lmfc_edge ? 1 : (lmfc_cnt + 1) % MF;
    early = 1'b0;
    check("model",
          64'({bus.data_o, bus.datak_o, bus.state_o, bus.tx_ready_o, bus.resync_cnt_o}),
          64'({md_data, md_k, 2'(md_mode), (md_mode == 2), 8'(md_rcnt)}));
  endtask

  task automatic wait_state(input int st, input int limit, input string name);
    int n;
    n = 0;
    while (bus.state_o != 2'(st) && n < limit) begin
      cycle();
      n++;
    end
    check(name, 64'(bus.state_o), 64'(st));
  endtask

  initial begin
    vec_t tab [12];
    int ilas_len;
    int run;
    bit lvl;

    tab[0]  = '{0,  32'h0,         32'hBCBC_BCBC, 4'hF, 2'd1, 1'b0};
    tab[1]  = '{1,  32'h0,         32'h011C_011C, 4'h5, 2'd1, 1'b0};
    tab[2]  = '{2,  32'h0,         32'h0302_0302, 4'h0, 2'd1, 1'b0};
    tab[3]  = '{8,  32'h0,         32'h7C0E_7C0E, 4'hA, 2'd1, 1'b0};
    tab[4]  = '{9,  32'h0,         32'h9C1C_9C1C, 4'hF, 2'd1, 1'b0};
    tab[5]  = '{10, 32'h0,         32'hA1A0_A1A0, 4'h0, 2'd1, 1'b0};
    tab[6]  = '{11, 32'h0,         32'hA3A2_A3A2, 4'h0, 2'd1, 1'b0};
    tab[7]  = '{16, 32'h0,         32'h7CAC_7CAC, 4'hA, 2'd1, 1'b0};
    tab[8]  = '{17, 32'h0,         32'h011C_011C, 4'h5, 2'd1, 1'b0};
    tab[9]  = '{32, 32'hDEAD_BEEF, 32'h7C0E_7C0E, 4'hA, 2'd2, 1'b1};
    tab[10] = '{33, 32'h1234_5678, 32'hDEAD_BEEF, 4'h0, 2'd2, 1'b1};
    tab[11] = '{34, 32'h0,         32'h1234_5678, 4'h0, 2'd2, 1'b1};

    for (int n = 0; n < 14; n++) cfg_oct[n] = 8'(8'hA0 + n);
    load_cfg();
    rst = 1'b1;
    bus.sync_n = 1'b1;
    bus.data_i = '0;
    bus.lmfc_edge = 1'b0;

    repeat (3) cycle();
    check("reset_outputs",
          64'({bus.data_o, bus.datak_o, bus.state_o, bus.tx_ready_o, bus.resync_cnt_o}), 64'(0));
    rst = 1'b0;

    // SYNC~ never asserted: CGS indefinitely
    repeat (40) cycle();
    check("cgs_hold", 64'({bus.data_o, bus.datak_o, bus.state_o}),
          64'({32'hBCBC_BCBC, 4'hF, 2'd0}));

    bus.sync_n = 1'b0;
    repeat (20) cycle();
    bus.sync_n = 1'b1;
    wait_state(1, 40, "ilas_enter");

    begin
      int off;
      off = 0;
      for (int i = 0; i < 12; i++) begin
        while (off < tab[i].off) begin
          cycle();
          off++;
        end
        check($sformatf("vec%0d", i),
              64'({bus.data_o, bus.datak_o, bus.state_o, bus.tx_ready_o}),
              64'({tab[i].data, tab[i].k, tab[i].st, tab[i].rdy}));
        bus.data_i = tab[i].din;
      end
    end

    // Short SYNC~ glitch in DATA is filtered out
    bus.sync_n = 1'b0;
    repeat (3) cycle();
    bus.sync_n = 1'b1;
    repeat (10) cycle();
    check("glitch_state", 64'(bus.state_o), 64'(2));
    check("glitch_cnt", 64'(bus.resync_cnt_o), 64'(0));

    bus.sync_n = 1'b0;
    repeat (6) cycle();
    check("resync_state", 64'(bus.state_o), 64'(0));
    check("resync_cnt", 64'(bus.resync_cnt_o), 64'(1));
    cycle();
    check("resync_bc", 64'({bus.data_o, bus.datak_o}), 64'({32'hBCBC_BCBC, 4'hF}));
    bus.sync_n = 1'b1;
    wait_state(1, 60, "resync_ilas");

    // Reset in ILAS multiframe 2; armed must be cleared afterwards
    repeat (2 * MF + 3) cycle();
    rst = 1'b1;
    cycle();
    check("rst_mid",
          64'({bus.data_o, bus.datak_o, bus.state_o, bus.tx_ready_o, bus.resync_cnt_o}), 64'(0));
    rst = 1'b0;
    repeat (40) cycle();
    check("rst_disarm", 64'(bus.state_o), 64'(0));

    // Early lmfc_edge at beat 5 of ILAS multiframe 0
    bus.sync_n = 1'b0;
    repeat (4) cycle();
    bus.sync_n = 1'b1;
    wait_state(1, 60, "ilas_again");
    repeat (5) cycle();
    early = 1'b1;
    cycle();
    check("early_restart", 64'({bus.data_o, bus.datak_o}), 64'({32'h011C_011C, 4'h5}));
    ilas_len = 7;
    while (bus.state_o == 2'd1 && ilas_len < 100) begin
      cycle();
      if (bus.state_o == 2'd1) ilas_len++;
    end
    check("early_ilas_len", 64'(ilas_len), 64'(37));
    check("early_data", 64'(bus.state_o), 64'(2));

    // Randomized run against the model
    for (int n = 0; n < 14; n++) cfg_oct[n] = 8'($urandom);
    load_cfg();
    run = 0;
    lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = lvl ? int'($urandom_range(60, 1)) : int'($urandom_range(12, 1));
      end
      run--;
      bus.sync_n = lvl;
      bus.data_i = $urandom;
      early = ($urandom_range(59, 0) == 0);
      rst = ($urandom_range(799, 0) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
